// File: rtl/switch_output_port_if.sv
// Handshake bundle between an output port, its input buffers, the arbiter and the link FIFO.
// The slave modport is the output-port view; master is the environment driving it.
interface switch_output_port_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned SelW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]        in_req;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN-1:0]        arb_bid;
  logic [SelW-1:0]          arb_select;
  logic                     arb_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  in_req, in_data, in_valid, arb_select, arb_valid, out_ready,
    output in_ready, arb_bid, out_data, out_valid, busy
  );

  modport master (
    output in_req, in_data, in_valid, arb_select, arb_valid, out_ready,
    input  in_ready, arb_bid, out_data, out_valid, busy
  );
endinterface

// File: rtl/switch_output_port.sv
// Switch output port: bids for head-of-line inputs, holds the arbiter grant for one whole
// packet and streams it through a registered valid/ready stage.
module switch_output_port #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned LEN_LSB = 0
) (
  input logic                 CLK,
  input logic                 nRST,
  switch_output_port_if.slave bus
);
  localparam int unsigned SelW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

  state_e            state_q;
  logic [SelW-1:0]   cur_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              first_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              can_accept, accept, is_tail, grant_ok;
  logic [DATA_W-1:0] flit;
  logic [LEN_W-1:0]  hdr_len, len_eff;
  logic [NUM_IN-1:0] in_ready, mask;

  always_comb begin
    can_accept = (state_q == StXfer) && (!out_valid_q || bus.out_ready);
    flit       = bus.in_data[32'(cur_q)*DATA_W +: DATA_W];
    accept     = can_accept && bus.in_valid[cur_q];
    hdr_len    = flit[LEN_LSB +: LEN_W];
    // A zero length field still carries the header itself.
    len_eff    = (hdr_len == '0) ? LenOne : hdr_len;
    is_tail    = first_q ? (len_eff == LenOne) : (remaining_q <= LenOne);
    grant_ok   = bus.arb_valid && (32'(bus.arb_select) < NUM_IN) &&
                 bus.in_req[bus.arb_select];
    in_ready   = '0;
    mask       = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = can_accept && (32'(cur_q) == i);
      // Drop the finished requester's bid early so the arbiter rotates past it.
      mask[i]     = (32'(cur_q) == i) && ((state_q == StRelease) || (accept && is_tail));
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.arb_bid   = nRST ? (bus.in_req & ~mask) : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != StIdle);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        out_data_q  <= flit;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          // A grant whose requester has gone away is stale and ignored.
          if (grant_ok) begin
            cur_q   <= bus.arb_select;
            first_q <= 1'b1;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (accept) begin
            first_q <= 1'b0;
            if (first_q) begin
              remaining_q <= len_eff - LenOne;
            end else if (remaining_q != '0) begin
              remaining_q <= remaining_q - LenOne;
            end
            if (is_tail) begin
              state_q <= StRelease;
            end
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_output_port.sv
// Bench for switch_output_port: sticky round-robin arbiter model, per-input flit sources and a
// scoreboard monitor that checks every flit leaving the port against the expected order.
module tb_switch_output_port;
  localparam int unsigned NUM_IN  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned LEN_LSB = 0;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  switch_output_port_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus ();

  switch_output_port #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .LEN_LSB(LEN_LSB)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  logic [NUM_IN-1:0]        req_hold, have, in_valid_r, acc;
  logic [NUM_IN*DATA_W-1:0] in_data_r;
  logic                     out_ready_r;
  logic [1:0]               arb_sel_q, force_sel, nxt_sel;
  logic                     arb_valid_q, arb_force, force_valid, nxt_found;

  assign bus.in_req     = req_hold | have;
  assign bus.in_valid   = in_valid_r;
  assign bus.in_data    = in_data_r;
  assign bus.out_ready  = out_ready_r;
  assign bus.arb_select = arb_sel_q;
  assign bus.arb_valid  = arb_valid_q;

  logic [DATA_W-1:0] src [NUM_IN][$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] want;
  int checks = 0, errors = 0, out_cnt = 0;

  // Sticky round-robin arbiter: keeps its winner while it still bids, else rotates.
  always_comb begin
    int idx;
    nxt_sel   = arb_sel_q;
    nxt_found = 1'b0;
    idx       = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = (int'(arb_sel_q) + k) % NUM_IN;
      if (bus.arb_bid[idx]) begin
        nxt_found = 1'b1;
        nxt_sel   = 2'(idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      arb_sel_q   <= 2'(NUM_IN - 1);
      arb_valid_q <= 1'b0;
    end else if (arb_force) begin
      arb_sel_q   <= force_sel;
      arb_valid_q <= force_valid;
    end else if (!(arb_valid_q && bus.arb_bid[arb_sel_q])) begin
      arb_valid_q <= nxt_found;
      if (nxt_found) arb_sel_q <= nxt_sel;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_IN; i++) begin
      have[i]       = (src[i].size() != 0);
      in_valid_r[i] = have[i];
      in_data_r[i*DATA_W +: DATA_W] = have[i] ? src[i][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Header plus nbody body flits; the expected stream grows in the order sends are issued.
  task automatic send(input int port, input logic [DATA_W-1:0] hdr, input int nbody);
    logic [DATA_W-1:0] f;
    src[port].push_back(hdr);
    exp_q.push_back(hdr);
    for (int k = 1; k <= nbody; k++) begin
      f = hdr | (DATA_W'(k) << 8);
      src[port].push_back(f);
      exp_q.push_back(f);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    for (int i = 0; i < NUM_IN; i++) src[i].delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Flit sources: pop whatever the DUT accepted at the edge just passed.
  initial begin
    acc = '0;
    forever begin
      @(negedge CLK);
      acc = bus.in_valid & bus.in_ready;
      @(posedge CLK);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (acc[i] && src[i].size() != 0) void'(src[i].pop_front());
      end
      refresh();
    end
  end

  always @(negedge CLK) begin
    if (nRST && bus.out_valid && out_ready_r) begin
      checks++;
      out_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", bus.out_data);
      end else begin
        want = exp_q.pop_front();
        if (bus.out_data !== want) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", bus.out_data, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit tailseen, found;
    int vcnt, base;
    nRST = 1'b0; req_hold = '0; out_ready_r = 1'b1; arb_force = 1'b0;
    force_valid = 1'b0; force_sel = '0; in_valid_r = '0; in_data_r = '0; have = '0;

    // Reset state, with every input requesting.
    req_hold = 4'hF;
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_arb_bid", 64'(bus.arb_bid), 64'd0);
    req_hold = '0;
    tick();
    nRST = 1'b1;
    tick();

    // Single len=3 packet from input 1.
    req_hold = 4'b0010;
    send(1, 32'hA100_0003, 2);
    refresh();
    @(negedge CLK);
    check("single_bid", 64'(bus.arb_bid), 64'b0010);
    tailseen = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 20 && !tailseen; n++) begin
      @(negedge CLK);
      if (bus.out_valid) vcnt++;
      if (bus.in_valid[1] && bus.in_ready[1] && src[1].size() == 1) tailseen = 1'b1;
      else tick();
    end
    check("single_tail_seen", 64'(tailseen), 64'd1);
    check("single_bid_tail", 64'(bus.arb_bid), 64'd0);
    tick();
    @(negedge CLK);
    if (bus.out_valid) vcnt++;
    check("single_release", 64'({bus.busy, bus.in_ready, bus.arb_bid}), 64'h100);
    req_hold = '0;
    tick();
    @(negedge CLK);
    if (bus.out_valid) vcnt++;
    check("single_valid_cycles", 64'(vcnt), 64'd3);
    check("single_busy_idle", 64'(bus.busy), 64'd0);
    wait_drain(5, "single_drain");

    // Round robin across all inputs: expected order 0,1,2,3,0.
    do_reset();
    send(0, 32'hB000_0002, 1);
    send(1, 32'hB001_0002, 1);
    send(2, 32'hB002_0002, 1);
    send(3, 32'hB003_0002, 1);
    send(0, 32'hB010_0002, 1);
    refresh();
    wait_drain(100, "rr_drain");
    tick(); tick(); tick();
    check("rr_busy_idle", 64'(bus.busy), 64'd0);

    // Backpressure: len=4, downstream stalls for 3 cycles after the header appears.
    send(2, 32'hD200_0004, 3);
    refresh();
    for (int n = 0; n < 20; n++) begin
      if (bus.out_valid) break;
      tick();
    end
    check("bp_first_valid", 64'(bus.out_valid), 64'd1);
    out_ready_r = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      check("bp_stall_data", 64'(bus.out_data), 64'hD200_0004);
      check("bp_stall_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10000);
      tick();
    end
    out_ready_r = 1'b1;
    wait_drain(30, "bp_drain");

    // len=0 on input 3, then len=1 on input 0: single-flit packets.
    send(3, 32'hC300_0000, 0);
    refresh();
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge CLK);
      if (bus.in_valid[3] && bus.in_ready[3]) found = 1'b1;
      else tick();
    end
    check("len0_accept", 64'(found), 64'd1);
    tick();
    @(negedge CLK);
    check("len0_release", 64'({bus.busy, bus.in_ready}), 64'b10000);
    tick();
    @(negedge CLK);
    check("len0_idle", 64'(bus.busy), 64'd0);
    send(0, 32'hC000_0001, 0);
    refresh();
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge CLK);
      if (bus.in_valid[0] && bus.in_ready[0]) found = 1'b1;
      else tick();
    end
    check("len1_accept", 64'(found), 64'd1);
    tick();
    @(negedge CLK);
    check("len1_release", 64'({bus.busy, bus.in_ready}), 64'b10000);
    tick();
    @(negedge CLK);
    check("len1_idle", 64'(bus.busy), 64'd0);
    wait_drain(5, "len01_drain");

    // Stale grant: arbiter points at input 2 which is not requesting.
    arb_force = 1'b1; force_valid = 1'b1; force_sel = 2'd2;
    tick();
    req_hold = 4'b1011;
    for (int n = 0; n < 5; n++) begin
      tick();
      @(negedge CLK);
      check("stale_idle", 64'({bus.busy, bus.in_ready}), 64'd0);
    end
    tick();
    req_hold = '0;
    tick();
    arb_force = 1'b0;
    tick();

    // Reset in the middle of a len=5 packet, then a fresh packet.
    send(1, 32'hE100_0005, 4);
    refresh();
    base = out_cnt;
    for (int n = 0; n < 30; n++) begin
      if (out_cnt - base >= 2) break;
      tick();
    end
    check("rst_mid_progress", 64'(out_cnt - base), 64'd2);
    nRST = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({bus.out_valid, bus.busy}), 64'd0);
    for (int i = 0; i < NUM_IN; i++) src[i].delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    nRST = 1'b1;
    tick();
    send(1, 32'hE200_0002, 1);
    refresh();
    wait_drain(30, "post_rst_drain");

    tick(); tick(); tick();
    check("final_busy", 64'(bus.busy), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
